apu_pulse: RTL

- NES-style pulse (square-wave) channel sitting directly downstream of the serial register decoder.
- Consumes the four decoded pulse registers plus per-register write strobes.
- Produces a 4-bit amplitude sample for the mixer.
- Frame-sequencer ticks and the APU clock enable arrive as single-cycle strobes from the shared timing block.

---
 rtl/apu_pulse.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/apu_pulse.sv
// NES-style pulse channel: duty sequencer, length counter, envelope and sweep
// driven from decoded pulse registers, producing a registered 4-bit sample.
module apu_pulse #(
    parameter bit SWEEP_ONES = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_ce,
    input  logic       quarter_frame,
    input  logic       half_frame,
    input  logic       enable,
    input  logic [7:0] reg_0,
    input  logic [7:0] reg_1,
    input  logic [7:0] reg_2,
    input  logic [7:0] reg_3,
    input  logic [3:0] reg_wr,
    output logic [3:0] pulse_out,
    output logic       active
);

    logic [10:0] period_q, period_d;
    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  length_q, length_d;
    logic [3:0]  decay_q, decay_d;
    logic [3:0]  env_div_q, env_div_d;
    logic        env_start_q, env_start_d;
    logic [2:0]  sweep_div_q, sweep_div_d;
    logic        sweep_reload_q, sweep_reload_d;
    logic [3:0]  pulse_q, pulse_d;
    logic        active_q, active_d;

    logic [1:0]  duty;
    logic        halt, const_vol, sw_en, sw_neg;
    logic [3:0]  vol_v;
    logic [2:0]  sw_p, sw_s;
    logic [11:0] delta, target;
    logic        mute, seq_bit;
    logic [7:0]  duty_pat, len_lut;
    logic [3:0]  volume;

    assign duty      = reg_0[7:6];
    assign halt      = reg_0[5];
    assign const_vol = reg_0[4];
    assign vol_v     = reg_0[3:0];
    assign sw_en     = reg_1[7];
    assign sw_p      = reg_1[6:4];
    assign sw_neg    = reg_1[3];
    assign sw_s      = reg_1[2:0];

    assign delta = {1'b0, period_q >> sw_s};

    always_comb begin
        if (sw_neg) begin
            target = {1'b0, period_q} - delta - (SWEEP_ONES ? 12'd1 : 12'd0);
        end else begin
            target = {1'b0, period_q} + delta;
        end
    end

    // target[11] set means the add overflowed past 0x7FF
    assign mute = (period_q < 11'd8) || (!sw_neg && target[11]);

    always_comb begin
        unique case (duty)
            2'd0: duty_pat = 8'b0000_0010;
            2'd1: duty_pat = 8'b0000_0110;
            2'd2: duty_pat = 8'b0001_1110;
            default: duty_pat = 8'b1111_1001;
        endcase
    end

    assign seq_bit = duty_pat[step_q];
    assign volume  = const_vol ? vol_v : decay_q;

    always_comb begin
        case (reg_3[7:3])
            5'd0:  len_lut = 8'd10;   5'd1:  len_lut = 8'd254;
            5'd2:  len_lut = 8'd20;   5'd3:  len_lut = 8'd2;
            5'd4:  len_lut = 8'd40;   5'd5:  len_lut = 8'd4;
            5'd6:  len_lut = 8'd80;   5'd7:  len_lut = 8'd6;
            5'd8:  len_lut = 8'd160;  5'd9:  len_lut = 8'd8;
            5'd10: len_lut = 8'd60;   5'd11: len_lut = 8'd10;
            5'd12: len_lut = 8'd14;   5'd13: len_lut = 8'd12;
            5'd14: len_lut = 8'd26;   5'd15: len_lut = 8'd14;
            5'd16: len_lut = 8'd12;   5'd17: len_lut = 8'd16;
            5'd18: len_lut = 8'd24;   5'd19: len_lut = 8'd18;
            5'd20: len_lut = 8'd48;   5'd21: len_lut = 8'd20;
            5'd22: len_lut = 8'd96;   5'd23: len_lut = 8'd22;
            5'd24: len_lut = 8'd192;  5'd25: len_lut = 8'd24;
            5'd26: len_lut = 8'd72;   5'd27: len_lut = 8'd26;
            5'd28: len_lut = 8'd16;   5'd29: len_lut = 8'd28;
            5'd30: len_lut = 8'd32;   default: len_lut = 8'd30;
        endcase
    end

    always_comb begin
        period_d       = period_q;
        timer_d        = timer_q;
        step_d         = step_q;
        length_d       = length_q;
        decay_d        = decay_q;
        env_div_d      = env_div_q;
        env_start_d    = env_start_q;
        sweep_div_d    = sweep_div_q;
        sweep_reload_d = sweep_reload_q;

        if (apu_ce) begin
            if (timer_q == 11'd0) begin
                timer_d = period_q;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end
        if (reg_wr[3]) step_d = 3'd0;

        if (!enable) begin
            length_d = 8'd0;
        end else if (reg_wr[3]) begin
            length_d = len_lut;
        end else if (half_frame && length_q != 8'd0 && !halt) begin
            length_d = length_q - 8'd1;
        end

        if (quarter_frame) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = 4'd15;
                env_div_d   = vol_v;
            end else if (env_div_q == 4'd0) begin
                env_div_d = vol_v;
                if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
                else if (halt)       decay_d = 4'd15;
            end else begin
                env_div_d = env_div_q - 4'd1;
            end
        end
        if (reg_wr[3]) env_start_d = 1'b1;

        if (half_frame) begin
            if (sweep_div_q == 3'd0 && sw_en && sw_s != 3'd0 && !mute) begin
                period_d = target[10:0];
            end
            if (sweep_div_q == 3'd0 || sweep_reload_q) begin
                sweep_div_d    = sw_p;
                sweep_reload_d = 1'b0;
            end else begin
                sweep_div_d = sweep_div_q - 3'd1;
            end
        end
        if (reg_wr[1]) sweep_reload_d = 1'b1;

        // A register write replaces any sweep result from the same cycle
        if (reg_wr[2] || reg_wr[3]) begin
            period_d = {reg_wr[3] ? reg_3[2:0] : period_q[10:8],
                        reg_wr[2] ? reg_2 : period_q[7:0]};
        end

        pulse_d  = (seq_bit && length_q != 8'd0 && !mute) ? volume : 4'd0;
        active_d = (length_q != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q       <= '0;
            timer_q        <= '0;
            step_q         <= '0;
            length_q       <= '0;
            decay_q        <= '0;
            env_div_q      <= '0;
            env_start_q    <= 1'b0;
            sweep_div_q    <= '0;
            sweep_reload_q <= 1'b0;
            pulse_q        <= '0;
            active_q       <= 1'b0;
        end else begin
            period_q       <= period_d;
            timer_q        <= timer_d;
            step_q         <= step_d;
            length_q       <= length_d;
            decay_q        <= decay_d;
            env_div_q      <= env_div_d;
            env_start_q    <= env_start_d;
            sweep_div_q    <= sweep_div_d;
            sweep_reload_q <= sweep_reload_d;
            pulse_q        <= pulse_d;
            active_q       <= active_d;
        end
    end

    assign pulse_out = pulse_q;
    assign active    = active_q;

endmodule
